// File: rtl/clk_div_multi.sv
// clk_div_multi: CH independent programmable clock dividers / PWM generators.
//
// Each channel runs a W-bit counter 0..P and wraps. Outputs are registered
// from the next-state counter, so out_o lines up with the counter value seen
// in the same cycle. Configuration writes go straight to the active
// registers while a channel is disabled. While it is enabled they go to a
// shadow copy that is applied at the next wrap, or immediately when en_i
// falls.
//
// Ports:
//   clk_i     system clock, rising edge
//   rst_i     asynchronous active-high reset
//   en_i      [CH]  per-channel run enable
//   wr_i      configuration write strobe
//   sel_i     [SW]  target channel; indices >= CH match no channel
//   period_i  [W]   period register P (period = P+1 cycles)
//   duty_i    [W]   duty register D (high cycles, PWM / one-shot)
//   mode_i    [2]   0 off, 1 square, 2 PWM, 3 one-shot
//   out_o     [CH]  divided / PWM output
//   tick_o    [CH]  one-cycle pulse after each wrap
module clk_div_multi #(
  parameter int         CH         = 4,
  parameter int         W          = 26,
  parameter int         DEF_PERIOD = 49999999,
  parameter int         DEF_DUTY   = 25000000,
  parameter logic [1:0] DEF_MODE   = 2'd1,
  localparam int        SW         = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [CH-1:0] en_i,
  input  logic          wr_i,
  input  logic [SW-1:0] sel_i,
  input  logic [W-1:0]  period_i,
  input  logic [W-1:0]  duty_i,
  input  logic [1:0]    mode_i,
  output logic [CH-1:0] out_o,
  output logic [CH-1:0] tick_o
);

  // Output level for counter value c under the given configuration.
  // One-shot shares the PWM test; c never exceeds P, so c < D gives min(D, P+1).
  function automatic logic high_cond(input logic [1:0] m, input logic [W-1:0] c,
                                     input logic [W-1:0] p, input logic [W-1:0] d);
    logic [W:0] half;
    half = ({1'b0, p} + {{W{1'b0}}, 1'b1}) >> 1;
    case (m)
      2'd1:    high_cond = ({1'b0, c} < half);
      2'd2,
      2'd3:    high_cond = (c < d);
      default: high_cond = 1'b0;
    endcase
  endfunction

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [W-1:0] cnt_q, cnt_d, per_q, per_d, duty_q, duty_d;
    logic [W-1:0] sper_q, sper_d, sduty_q, sduty_d;
    logic [1:0]   mode_q, mode_d, smode_q, smode_d;
    logic         pend_q, pend_d, run_q, run_d, done_q, done_d;
    logic         out_q, out_d, tick_q, tick_d;
    logic         hit, wrap;

    always_comb begin
      hit     = wr_i && (sel_i == SW'(g));
      wrap    = 1'b0;
      cnt_d   = cnt_q;
      per_d   = per_q;
      duty_d  = duty_q;
      mode_d  = mode_q;
      sper_d  = sper_q;
      sduty_d = sduty_q;
      smode_d = smode_q;
      pend_d  = pend_q;
      run_d   = run_q;
      done_d  = done_q;
      out_d   = 1'b0;
      tick_d  = 1'b0;
      if (!en_i[g]) begin
        // Disabled: park at 0; a pending shadow is flushed, and a write on
        // this edge lands directly in the active registers and wins.
        cnt_d  = '0;
        run_d  = 1'b0;
        done_d = 1'b0;
        if (pend_q) begin
          per_d  = sper_q;
          duty_d = sduty_q;
          mode_d = smode_q;
          pend_d = 1'b0;
        end
        if (hit) begin
          per_d  = period_i;
          duty_d = duty_i;
          mode_d = mode_i;
        end
      end else begin
        if (hit) begin
          sper_d  = period_i;
          sduty_d = duty_i;
          smode_d = mode_i;
          pend_d  = 1'b1;
        end
        if (!run_q) begin
          // First enabled edge presents counter 0 with its output level.
          run_d = 1'b1;
          cnt_d = '0;
          out_d = high_cond(mode_q, '0, per_q, duty_q);
        end else if (!done_q) begin
          wrap   = (cnt_q == per_q);
          tick_d = wrap;
          if (wrap) begin
            cnt_d = '0;
            // The shadow applied here is the one held before this edge; a
            // write on the same edge stays pending for the next wrap.
            if (pend_q) begin
              per_d  = sper_q;
              duty_d = sduty_q;
              mode_d = smode_q;
              if (!hit) pend_d = 1'b0;
            end
            if (mode_q == 2'd3) done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + W'(1);
          end
          out_d = !done_d && high_cond(mode_d, cnt_d, per_d, duty_d);
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q   <= '0;
        per_q   <= W'(DEF_PERIOD);
        duty_q  <= W'(DEF_DUTY);
        mode_q  <= DEF_MODE;
        sper_q  <= W'(DEF_PERIOD);
        sduty_q <= W'(DEF_DUTY);
        smode_q <= DEF_MODE;
        pend_q  <= 1'b0;
        run_q   <= 1'b0;
        done_q  <= 1'b0;
        out_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        per_q   <= per_d;
        duty_q  <= duty_d;
        mode_q  <= mode_d;
        sper_q  <= sper_d;
        sduty_q <= sduty_d;
        smode_q <= smode_d;
        pend_q  <= pend_d;
        run_q   <= run_d;
        done_q  <= done_d;
        out_q   <= out_d;
        tick_q  <= tick_d;
      end
    end

    assign out_o[g]  = out_q;
    assign tick_o[g] = tick_q;
  end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter CH, default 4, number of independent divider channels (1..8).
REQ-002 Parameter W, default 26, counter/period/duty width in bits (2..32).
REQ-003 Parameter DEF_PERIOD, default 49999999, reset value of every channel's period register P.
REQ-004 Parameter DEF_DUTY, default 25000000, reset value of every channel's duty register D.
REQ-005 Parameter DEF_MODE, default 2'd1, reset value of every channel's mode register.
REQ-006 clk_i  input  1  system clock; all state changes on the rising edge.
REQ-007 rst_i  input  1  reset, asynchronous, active-high.
REQ-008 en_i  input  CH  per-channel run enable, level-sensitive.
REQ-009 wr_i  input  1  configuration write strobe, one cycle per write.
REQ-010 sel_i  input  clog2(CH) (min 1)  target channel of the write; an index >= CH is ignored.
REQ-011 period_i  input  W  new P; the channel period is P+1 cycles.
REQ-012 duty_i  input  W  new D, the high-time in cycles for PWM and one-shot modes.
REQ-013 mode_i  input  2  new mode: 0 off, 1 square, 2 PWM, 3 one-shot.
REQ-014 out_o  output  CH  registered divided/PWM output per channel.
REQ-015 tick_o  output  CH  registered one-cycle pulse per channel at each period wrap.

Function
REQ-016 Each channel SHALL hold a W-bit counter, active registers P/D/mode, shadow registers P/D/mode, and a pending flag.
REQ-017 A write to a channel whose en_i is low SHALL load the active registers directly on that edge.
REQ-018 A write to a channel whose en_i is high SHALL load the shadow registers and set pending.
REQ-019 The shadow registers SHALL be copied to the active registers, and pending cleared, on that channel's next wrap.
REQ-020 A second write before the wrap SHALL overwrite the shadow registers; only the last write takes effect.
REQ-021 While en_i is high, the counter SHALL run 0,1,...,P and then wrap to 0; the wrap edge is the one where the counter equals P.
REQ-022 tick_o SHALL be high for exactly the one cycle following each wrap edge.
REQ-023 P=0 SHALL give a counter fixed at 0, with a wrap and tick_o high on every enabled cycle.
REQ-024 Mode 0: out_o SHALL be low and tick_o SHALL still be generated.
REQ-025 Mode 1: out_o SHALL be high for the first floor((P+1)/2) cycles of each period and low for the rest.
REQ-026 Mode 2: out_o SHALL be high in each cycle whose counter value c satisfies c < D.
REQ-027 Mode 2 boundaries: D=0 SHALL give out_o always low; D > P SHALL give out_o always high.
REQ-028 Mode 3: from enable, out_o SHALL be high for min(D, P+1) cycles and then stay low.
REQ-029 Mode 3: after its first wrap the counter SHALL stop at 0 with no further ticks until en_i falls and rises again.
REQ-030 out_o SHALL be registered so that out_o follows the counter value with zero cycles of relative skew.
REQ-031 The first enabled cycle (counter = 0) SHALL therefore present out_o high when the mode's high condition holds for c = 0.
REQ-032 When en_i falls, the counter SHALL clear to 0 and out_o and tick_o SHALL be low on the next cycle.
REQ-033 When en_i falls, a pending shadow SHALL be applied to the active registers immediately.
REQ-034 A write and a wrap on the same edge SHALL apply the old shadow at the wrap; the new write goes to the shadow and stays pending.
REQ-035 Channels SHALL be fully independent; a write affects only the channel selected by sel_i.

Reset
REQ-036 While rst_i is high, all counters SHALL be 0, out_o and tick_o SHALL be 0, and pending flags SHALL be clear.
REQ-037 While rst_i is high, active and shadow registers SHALL hold DEF_PERIOD, DEF_DUTY and DEF_MODE.
REQ-038 Reset asserted mid-period SHALL take effect immediately, without waiting for a clock edge.
REQ-039 After reset is released, the first counting edge SHALL be the first rising clk_i edge with en_i high.

Verification
REQ-040 Channel 0: write P=9, mode 1 while disabled, then enable -> out_o[0] is 5 high / 5 low repeating, and tick_o[0] pulses every 10 cycles.
REQ-041 Channel 1: mode 2, P=7, with D=0, then D=3, then D=8 -> out_o[1] is always low, then 3 high / 5 low, then always high.
REQ-042 Channel 2: running P=9, D=2, mode 2; write P=3 at counter=4 -> old period completes (6 more cycles), then the period is 4 cycles.
REQ-043 Channel 3: mode 3, D=4, P=19, enable -> out_o[3] high for 4 cycles, exactly one tick at cycle 20, then silent; toggling en_i restarts the pulse.
REQ-044 Reset pulse mid-period with all channels enabled -> all outputs 0 asynchronously; after release, each channel runs DEF_PERIOD/DEF_DUTY/DEF_MODE from counter 0.
REQ-045 Write with sel_i >= CH, and a write on the same edge as a wrap -> first changes nothing; second keeps the new value pending until the following wrap.
